decryption_demux: RTL and testbench

Word-to-byte front end of the decryption subsystem. Accepts 32-bit ciphertext words from the master side, and serialises each word into four 8-bit bytes, MSB first, on the system-side byte bus. Routes the bytes to one of three decryption engines (0 = caesar, 1 = scytale, 2 = zigzag) through a one-hot valid, and holds the stream while the selected engine reports busy. Sits directly upstream of `zigzag_decryption` and its sibling engines, driving their `data_i`/`valid_i` inputs.

---
 rtl/decryption_demux.sv | 86 ++++++++
 tb/tb_decryption_demux.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/decryption_demux.sv
// Word-to-byte front end: serialises 32-bit ciphertext words MSB-first onto a shared
// byte bus and steers them to one of three decryption engines via a one-hot valid.
module decryption_demux #(
  parameter int MST_DWIDTH = 32,
  parameter int SYS_DWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            select,
  input  logic [MST_DWIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            busy_i,
  output logic [SYS_DWIDTH-1:0] data_o,
  output logic [2:0]            valid_o
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                  state;
  logic [1:0]              idx;
  logic [MST_DWIDTH-1:0]   word_q;
  logic [1:0]              sel_q;
  logic                    sel_busy;

  // Only the engine the word is routed to can stall the stream.
  always_comb begin
    sel_busy = 1'b0;
    case (sel_q)
      2'd0:    sel_busy = busy_i[0];
      2'd1:    sel_busy = busy_i[1];
      2'd2:    sel_busy = busy_i[2];
      default: sel_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= 2'd0;
      word_q  <= '0;
      sel_q   <= 2'd0;
      ready_o <= 1'b1;
      data_o  <= '0;
      valid_o <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          valid_o <= 3'b000;
          // A select of 3 names no engine, so that word is consumed and dropped.
          if (valid_i && ready_o && (select != 2'd3)) begin
            word_q  <= data_i;
            sel_q   <= select;
            idx     <= 2'd0;
            state   <= SEND;
            ready_o <= 1'b0;
          end
        end
        SEND: begin
          if (sel_busy) begin
            valid_o <= 3'b000;
          end else begin
            // The word register shifts left so its top byte is always the next to send.
            data_o  <= word_q[MST_DWIDTH-1 -: SYS_DWIDTH];
            word_q  <= word_q << SYS_DWIDTH;
            valid_o <= 3'b001 << sel_q;
            idx     <= idx + 2'd1;
            if (idx == 2'd3) begin
              state   <= IDLE;
              ready_o <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b1;
          valid_o <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decryption_demux.sv
// Scoreboard bench for decryption_demux: stimulus queues expected bytes, a monitor
// pops and compares them whenever a byte valid is seen.
module tb_decryption_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  select = 2'd0;
  logic [31:0] data_i = 32'h0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [2:0]  busy_i = 3'b000;
  logic [7:0]  data_o;
  logic [2:0]  valid_o;

  int checks = 0;
  int failures = 0;
  logic [10:0] exp_q[$];

  decryption_demux #(.MST_DWIDTH(32), .SYS_DWIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .select(select), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .busy_i(busy_i), .data_o(data_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic pushBytes(input logic [31:0] w, input logic [1:0] s, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({3'b001 << s, w[31-8*i -: 8]});
  endtask

  task automatic waitReady();
    int n = 0;
    while (ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) checkOutput("ready_timeout", {31'h0, ready_o}, 1);
  endtask

  // Drives one word at a negedge and returns at the negedge after its transfer edge.
  task automatic applyStimulus(input logic [31:0] w, input logic [1:0] s);
    waitReady();
    data_i = w;
    select = s;
    valid_i = 1'b1;
    if (s != 2'd3) pushBytes(w, s, 4);
    @(negedge clk);
    valid_i = 1'b0;
    data_i = ~w;
    select = s + 2'd1;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((exp_q.size() != 0 || ready_o !== 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_queue", exp_q.size(), 0);
    checkOutput("drain_ready", {31'h0, ready_o}, 1);
  endtask

  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && valid_o !== 3'b000) begin
        checkOutput("valid_onehot", $countones(valid_o), 1);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_byte", {21'h0, valid_o, data_o}, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("byte", {21'h0, valid_o, data_o}, {21'h0, e});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", {31'h0, ready_o}, 1);
    checkOutput("reset_valid", {29'h0, valid_o}, 0);
    checkOutput("reset_data", {24'h0, data_o}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain word to engine 2.
    applyStimulus(32'h4142_4344, 2'd2);
    checkOutput("t1_ready_n0", {31'h0, ready_o}, 0);
    checkOutput("t1_valid_n0", {29'h0, valid_o}, 0);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      checkOutput("t1_valid", {29'h0, valid_o}, 3'b100);
      checkOutput("t1_ready", {31'h0, ready_o}, (j == 4) ? 1 : 0);
    end
    @(negedge clk);
    checkOutput("t1_valid_after", {29'h0, valid_o}, 0);
    checkOutput("t1_ready_after", {31'h0, ready_o}, 1);

    // Engine 0 stalls for three edges after the second byte.
    applyStimulus(32'hDEAD_BEEF, 2'd0);
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      checkOutput("t2_valid", {29'h0, valid_o}, (j >= 3 && j <= 5) ? 3'b000 : 3'b001);
      if (j >= 3 && j <= 5) checkOutput("t2_data_hold", {24'h0, data_o}, 32'hAD);
      if (j >= 6) checkOutput("t2_ready", {31'h0, ready_o}, (j == 7) ? 1 : 0);
      if (j == 2) busy_i = 3'b001;
      if (j == 5) busy_i = 3'b000;
    end

    // Busy of an unselected engine toggling must not disturb the stream.
    applyStimulus(32'hDEAD_BEEF, 2'd0);
    busy_i = 3'b010;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      checkOutput("t2b_valid", {29'h0, valid_o}, 3'b001);
      busy_i[1] = ~busy_i[1];
    end
    busy_i = 3'b000;
    checkOutput("t2b_ready", {31'h0, ready_o}, 1);

    // Invalid select drops words, including back-to-back ones.
    applyStimulus(32'h9988_7766, 2'd3);
    checkOutput("t3_ready", {31'h0, ready_o}, 1);
    checkOutput("t3_valid", {29'h0, valid_o}, 0);
    data_i = 32'h5555_AAAA;
    select = 2'd3;
    valid_i = 1'b1;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      checkOutput("t3_b2b_ready", {31'h0, ready_o}, 1);
      checkOutput("t3_b2b_valid", {29'h0, valid_o}, 0);
    end
    valid_i = 1'b0;
    applyStimulus(32'h0102_0304, 2'd1);
    waitDrain();

    // valid_i held high across two words: one idle cycle between streams.
    data_i = 32'h1111_1111;
    select = 2'd1;
    valid_i = 1'b1;
    pushBytes(32'h1111_1111, 2'd1, 4);
    pushBytes(32'h2222_2222, 2'd1, 4);
    @(negedge clk);
    data_i = 32'h2222_2222;
    checkOutput("t4_ready_n0", {31'h0, ready_o}, 0);
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      checkOutput("t4_valid", {29'h0, valid_o}, (j == 5) ? 3'b000 : 3'b010);
      checkOutput("t4_ready", {31'h0, ready_o}, (j == 4 || j == 9) ? 1 : 0);
      if (j == 5) valid_i = 1'b0;
    end
    waitDrain();

    // Reset mid-word discards the remaining bytes.
    data_i = 32'hCAFE_F00D;
    select = 2'd0;
    valid_i = 1'b1;
    pushBytes(32'hCAFE_F00D, 2'd0, 2);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_valid", {29'h0, valid_o}, 0);
    checkOutput("t5_rst_data", {24'h0, data_o}, 0);
    checkOutput("t5_rst_ready", {31'h0, ready_o}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t5_queue_empty", exp_q.size(), 0);
    applyStimulus(32'hA5A5_5A5A, 2'd2);
    waitDrain();

    // select/data_i wander during SEND; the in-flight word is unaffected.
    applyStimulus(32'h1357_9BDF, 2'd1);
    for (int j = 1; j <= 4; j++) begin
      data_i = $urandom;
      select = 2'(j % 3 == 1 ? 0 : 2);
      @(negedge clk);
      checkOutput("t6_valid", {29'h0, valid_o}, 3'b010);
    end
    waitDrain();

    @(negedge clk);
    checkOutput("end_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
